// File: rtl/arm_multicycle_ctrl_if.sv
// Instruction-field inputs and datapath control outputs of the multicycle ARM controller.
// The controller drives through the master modport; the datapath/instruction register side uses slave.
interface arm_multicycle_ctrl_if #(
    parameter int ALUCTRL_W = 3
);
    logic [3:0]           cond;
    logic [1:0]           op;
    logic [5:0]           funct;
    logic [3:0]           rd;
    logic [3:0]           ALUFlags;
    logic                 PCWrite;
    logic                 AdrSrc;
    logic                 MemW;
    logic                 IRWrite;
    logic                 RegW;
    logic                 WA14;
    logic [1:0]           ResultSrc;
    logic                 ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [1:0]           ImmSrc;
    logic [1:0]           RegSrc;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic [3:0]           Flags;

    // No valid/ready pair: the instruction fields are level signals held by the IR
    // and every control output is meaningful in every cycle it is presented.
    modport master (
        input  cond, op, funct, rd, ALUFlags,
        output PCWrite, AdrSrc, MemW, IRWrite, RegW, WA14, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, Flags
    );

    modport slave (
        output cond, op, funct, rd, ALUFlags,
        input  PCWrite, AdrSrc, MemW, IRWrite, RegW, WA14, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, Flags
    );
endinterface

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM-subset control unit: Moore FSM with memory wait states, NZCV flags and cond gating.
// Optional macro CTRL_BL_EN adds the LINK state for BL (writes PC to R14 before BRANCH).
module arm_multicycle_ctrl #(
    parameter int ALUCTRL_W = 3,
    parameter int MEM_LAT   = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    arm_multicycle_ctrl_if.master  bus,
    output logic [3:0]             state_o
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_LINK
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] flags_q, flags_d;
    logic       condex_q, condex_d;

    logic cond_ok, last;
    logic [ALUCTRL_W-1:0] alu_cmd, alu;
    logic cmd_wr, cmd_nzonly, cmd_cmp;
    logic pcw, adr, memw, irw, regw, wa14, asa;
    logic [1:0] rs, asb;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_FETCH;
            cnt_q    <= '0;
            flags_q  <= '0;
            condex_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            flags_q  <= flags_d;
            condex_q <= condex_d;
        end
    end

    assign last = (cnt_q == 4'(MEM_LAT));

    always_comb begin
        cond_ok = 1'b0;
        unique case (bus.cond)
            4'b0000: cond_ok = flags_q[2];
            4'b0001: cond_ok = !flags_q[2];
            4'b0010: cond_ok = flags_q[1];
            4'b0011: cond_ok = !flags_q[1];
            4'b0100: cond_ok = flags_q[3];
            4'b0101: cond_ok = !flags_q[3];
            4'b0110: cond_ok = flags_q[0];
            4'b0111: cond_ok = !flags_q[0];
            4'b1000: cond_ok = flags_q[1] && !flags_q[2];
            4'b1001: cond_ok = !flags_q[1] || flags_q[2];
            4'b1010: cond_ok = (flags_q[3] == flags_q[0]);
            4'b1011: cond_ok = (flags_q[3] != flags_q[0]);
            4'b1100: cond_ok = !flags_q[2] && (flags_q[3] == flags_q[0]);
            4'b1101: cond_ok = flags_q[2] || (flags_q[3] != flags_q[0]);
            4'b1110: cond_ok = 1'b1;
            4'b1111: cond_ok = 1'b0;
        endcase
    end

    // Unrecognised DP commands still compute ADD but never write the register file.
    always_comb begin
        alu_cmd    = '0;
        cmd_wr     = 1'b0;
        cmd_nzonly = 1'b0;
        cmd_cmp    = 1'b0;
        case (bus.funct[4:1])
            4'b0100: cmd_wr = 1'b1;
            4'b0010: begin alu_cmd = ALUCTRL_W'(1); cmd_wr = 1'b1; end
            4'b0000: begin alu_cmd = ALUCTRL_W'(2); cmd_wr = 1'b1; cmd_nzonly = 1'b1; end
            4'b1100: begin alu_cmd = ALUCTRL_W'(3); cmd_wr = 1'b1; cmd_nzonly = 1'b1; end
            4'b1010: begin alu_cmd = ALUCTRL_W'(1); cmd_cmp = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        flags_d  = flags_q;
        condex_d = condex_q;
        pcw = 1'b0; adr = 1'b0; memw = 1'b0; irw = 1'b0; regw = 1'b0; wa14 = 1'b0;
        asa = 1'b0; rs = 2'b00; asb = 2'b00; alu = '0;
        case (state_q)
            S_FETCH: begin
                irw = last; pcw = last; asa = 1'b1; asb = 2'b10; rs = 2'b10;
                if (last) state_d = S_DECODE;
                else      cnt_d   = cnt_q + 4'd1;
            end
            S_DECODE: begin
                asa = 1'b1; asb = 2'b10; rs = 2'b10;
                condex_d = cond_ok;
                case (bus.op)
                    2'b00: state_d = bus.funct[5] ? S_EXECI : S_EXECR;
                    2'b01: state_d = S_MEMADR;
`ifdef CTRL_BL_EN
                    2'b10: state_d = bus.funct[4] ? S_LINK : S_BRANCH;
`else
                    2'b10: state_d = S_BRANCH;
`endif
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                asb = 2'b01;
                state_d = bus.funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr = 1'b1;
                if (last) state_d = S_MEMWB;
                else      cnt_d   = cnt_q + 4'd1;
            end
            S_MEMWB: begin
                rs = 2'b01; regw = condex_q; pcw = condex_q && (bus.rd == 4'd15);
                state_d = S_FETCH;
            end
            S_MEMWRITE: begin
                adr = 1'b1; memw = condex_q && last;
                if (last) state_d = S_FETCH;
                else      cnt_d   = cnt_q + 4'd1;
            end
            S_EXECR, S_EXECI: begin
                asb = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                alu = alu_cmd;
                if (condex_q && (bus.funct[0] || cmd_cmp))
                    flags_d = cmd_nzonly ? {bus.ALUFlags[3:2], flags_q[1:0]} : bus.ALUFlags;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regw = condex_q && cmd_wr; pcw = condex_q && cmd_wr && (bus.rd == 4'd15);
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                asb = 2'b01; rs = 2'b10; pcw = condex_q;
                state_d = S_FETCH;
            end
`ifdef CTRL_BL_EN
            S_LINK: begin
                regw = condex_q; wa14 = condex_q; rs = 2'b11;
                state_d = S_BRANCH;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    assign bus.PCWrite    = pcw  && reset_n;
    assign bus.IRWrite    = irw  && reset_n;
    assign bus.RegW       = regw && reset_n;
    assign bus.MemW       = memw && reset_n;
    assign bus.WA14       = wa14 && reset_n;
    assign bus.AdrSrc     = adr;
    assign bus.ResultSrc  = rs;
    assign bus.ALUSrcA    = asa;
    assign bus.ALUSrcB    = asb;
    assign bus.ALUControl = alu;
    assign bus.ImmSrc     = bus.op;
    assign bus.RegSrc     = {bus.op == 2'b01, bus.op == 2'b10};
    assign bus.Flags      = flags_q;
    assign state_o        = state_q;
endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Randomized scoreboard bench for arm_multicycle_ctrl against a phase-list reference model.
module tb_arm_multicycle_ctrl;
    localparam int LAT = 2;
    localparam int W   = 22;
    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3, P_MEMWB = 4,
                   P_MEMWRITE = 5, P_EXECR = 6, P_EXECI = 7, P_ALUWB = 8, P_BRANCH = 9, P_LINK = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [3:0] state_dbg;
    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_bad = 0;
    logic [3:0] m_flags = 4'h0;
    bit m_cx = 1'b0;

    arm_multicycle_ctrl_if #(.ALUCTRL_W(3)) bus ();

    arm_multicycle_ctrl #(.ALUCTRL_W(3), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .state_o(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic bit cond_holds(logic [3:0] c, logic [3:0] f);
        bit n = f[3], z = f[2], cy = f[1], v = f[0];
        bit base;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return c[0] == 1'b0;
        endcase
        return c[0] ? !base : base;
    endfunction

    // ALU code, whether the result is written, whether only NZ are loaded
    function automatic void dp_cmd(logic [5:0] f, output logic [2:0] a, output bit wr, output bit nz);
        a = 3'd0; wr = 1'b0; nz = 1'b0;
        case (f[4:1])
            4'd4:  wr = 1'b1;
            4'd2:  begin a = 3'd1; wr = 1'b1; end
            4'd0:  begin a = 3'd2; wr = 1'b1; nz = 1'b1; end
            4'd12: begin a = 3'd3; wr = 1'b1; nz = 1'b1; end
            4'd10: a = 3'd1;
            default: ;
        endcase
    endfunction

    function automatic logic [W-1:0] exp_vec(int ph, bit last, bit cx, logic [3:0] flg,
                                              logic [1:0] op, logic [5:0] f, logic [3:0] rd);
        bit pcw = 0, adr = 0, memw = 0, irw = 0, regw = 0, wa14 = 0, asa = 0;
        logic [1:0] rs = 2'd0, asb = 2'd0;
        logic [2:0] alu = 3'd0, a;
        bit wr, nz;
        dp_cmd(f, a, wr, nz);
        case (ph)
            P_FETCH:    begin irw = last; pcw = last; asa = 1; asb = 2; rs = 2; end
            P_DECODE:   begin asa = 1; asb = 2; rs = 2; end
            P_MEMADR:   asb = 1;
            P_MEMREAD:  adr = 1;
            P_MEMWB:    begin rs = 1; regw = cx; pcw = cx && rd == 15; end
            P_MEMWRITE: begin adr = 1; memw = cx && last; end
            P_EXECR:    alu = a;
            P_EXECI:    begin asb = 1; alu = a; end
            P_ALUWB:    begin regw = cx && wr; pcw = cx && wr && rd == 15; end
            P_BRANCH:   begin asb = 1; rs = 2; pcw = cx; end
            P_LINK:     begin regw = cx; wa14 = cx; rs = 3; end
            default: ;
        endcase
        return {pcw, adr, memw, irw, regw, wa14, rs, asa, asb, op, op == 2'b01, op == 2'b10, alu, flg};
    endfunction

    // Runs one instruction; if rst_at indexes one of its cycles, reset_n is pulled low there.
    task automatic run_instr(logic [31:0] instr, logic [3:0] alf, int rst_at);
        logic [3:0] c = instr[31:28];
        logic [1:0] op = instr[27:26];
        logic [5:0] f = instr[25:20];
        logic [3:0] rd = instr[15:12];
        int ph_q[$];
        bit last_q[$];
        logic [2:0] a;
        bit wr, nz;
        logic [W-1:0] v;
        bus.cond = c; bus.op = op; bus.funct = f; bus.rd = rd; bus.ALUFlags = alf;
        for (int k = 0; k <= LAT; k++) begin ph_q.push_back(P_FETCH); last_q.push_back(k == LAT); end
        ph_q.push_back(P_DECODE); last_q.push_back(1);
        case (op)
            2'b00: begin
                ph_q.push_back(f[5] ? P_EXECI : P_EXECR); last_q.push_back(1);
                ph_q.push_back(P_ALUWB); last_q.push_back(1);
            end
            2'b01: begin
                ph_q.push_back(P_MEMADR); last_q.push_back(1);
                for (int k = 0; k <= LAT; k++) begin
                    ph_q.push_back(f[0] ? P_MEMREAD : P_MEMWRITE); last_q.push_back(k == LAT);
                end
                if (f[0]) begin ph_q.push_back(P_MEMWB); last_q.push_back(1); end
            end
            2'b10: begin
`ifdef CTRL_BL_EN
                if (f[4]) begin ph_q.push_back(P_LINK); last_q.push_back(1); end
`endif
                ph_q.push_back(P_BRANCH); last_q.push_back(1);
            end
            default: ;
        endcase
        for (int i = 0; i < ph_q.size(); i++) begin
            v = exp_vec(ph_q[i], last_q[i], m_cx, m_flags, op, f, rd);
            if (i == rst_at) begin
                reset_n = 1'b0;
                v[W-1] = 1'b0; v[W-3] = 1'b0; v[W-4] = 1'b0; v[W-5] = 1'b0; v[W-6] = 1'b0;
                exp_q.push_back(v);
                @(posedge clk); #1;
                reset_n = 1'b1;
                m_flags = 4'h0; m_cx = 1'b0;
                return;
            end
            exp_q.push_back(v);
            if (ph_q[i] == P_DECODE) m_cx = cond_holds(c, m_flags);
            if ((ph_q[i] == P_EXECR || ph_q[i] == P_EXECI) && m_cx) begin
                dp_cmd(f, a, wr, nz);
                if (f[0] || f[4:1] == 4'd10) m_flags = nz ? {alf[3:2], m_flags[1:0]} : alf;
            end
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] act, e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act = {bus.PCWrite, bus.AdrSrc, bus.MemW, bus.IRWrite, bus.RegW, bus.WA14,
                   bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.RegSrc,
                   bus.ALUControl, bus.Flags};
            n_vec++;
            if (act !== e) begin
                n_bad++;
                $display("FAIL vec%0d state=%0d got=%06h expected=%06h", n_vec, state_dbg, act, e);
            end
        end
    end

    initial begin
        logic [31:0] ins;
        logic [31:0] dir[9];
        int rst_at;
        dir = '{32'hE0855004, 32'hE2802005, 32'hE5802064, 32'hE5902060, 32'hEA000001,
                32'hE3500000, 32'h1AFFFFEF, 32'hE5802064, 32'hEB000004};
        bus.cond = 4'h0; bus.op = 2'b00; bus.funct = 6'h0; bus.rd = 4'h0; bus.ALUFlags = 4'h0;
        reset_n = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back({6'b0, 2'b10, 1'b1, 2'b10, 2'b00, 2'b00, 3'd0, 4'h0});
            @(posedge clk); #1;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 9; i++)
            run_instr(dir[i], (i == 5) ? 4'b0100 : 4'b1011, (i == 7) ? 6 : -1);
        for (int i = 0; i < 200; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 1) == 0) ins[31:28] = 4'hE;
            else ins[31:28] = 4'($urandom_range(0, 14));
            if ($urandom_range(0, 4) == 0) ins[15:12] = 4'hF;
            if ($urandom_range(0, 2) == 0) ins[20] = 1'b1;
            rst_at = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 10)) : -1;
            run_instr(ins, 4'($urandom_range(0, 15)), rst_at);
        end
        @(posedge clk); #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got=%0d pending expected=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
